mips_multicycle_ctrl: RTL and testbench

Multi-cycle MIPS control FSM: the issuing side of the ALU interface. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives `alu_select`, ALU operand muxes and datapath strobes, and consumes the ALU's `zero_flag` to resolve branches. It sits between the instruction register and the datapath (PC, register file, memory, ALU).

---
 rtl/mips_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back and drives the datapath.
// Define MIPS_CTRL_IMM_OPS_EN to enable addi/slti/andi/ori; otherwise those opcodes decode as illegal.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instr_opcode,
  input  logic [5:0] instr_funct,
  input  logic       zero_flag,
  output logic [3:0] alu_select,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [2:0] SRCB_REG   = 3'b000;
  localparam logic [2:0] SRCB_FOUR  = 3'b001;
  localparam logic [2:0] SRCB_SEXT  = 3'b010;
  localparam logic [2:0] SRCB_SEXT2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT  = 3'b100;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EX,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_IMM_EX,
    S_IMM_WB,
    S_ILLEGAL
  } state_t;

  state_t state_q, state_d;

  logic [3:0] r_alu;
  logic       r_legal;
  logic [3:0] imm_alu;
  logic [2:0] imm_src_b;
  logic       imm_op;
  logic       imm_legal;

  always_comb begin
    r_alu   = ALU_ADD;
    r_legal = 1'b1;
    case (instr_funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_alu   = ALU_ADD;
    imm_src_b = SRCB_SEXT;
    imm_op    = 1'b1;
    case (instr_opcode)
      OP_ADDI: begin imm_alu = ALU_ADD; imm_src_b = SRCB_SEXT; end
      OP_SLTI: begin imm_alu = ALU_SLT; imm_src_b = SRCB_SEXT; end
      OP_ANDI: begin imm_alu = ALU_AND; imm_src_b = SRCB_ZEXT; end
      OP_ORI:  begin imm_alu = ALU_OR;  imm_src_b = SRCB_ZEXT; end
      default: imm_op = 1'b0;
    endcase
  end

  // Without the immediate feature these opcodes fall through to ILLEGAL.
`ifdef MIPS_CTRL_IMM_OPS_EN
  assign imm_legal = imm_op;
`else
  assign imm_legal = 1'b0 & imm_op;
`endif

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (instr_opcode == OP_RTYPE && r_legal)                 state_d = S_R_EX;
        else if (instr_opcode == OP_LW || instr_opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (instr_opcode == OP_BEQ)                          state_d = S_BRANCH;
        else if (instr_opcode == OP_J)                            state_d = S_JUMP;
        else if (imm_legal)                                       state_d = S_IMM_EX;
        else                                                      state_d = S_ILLEGAL;
      end
      S_MEM_ADDR: state_d = (instr_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_R_EX:     state_d = S_R_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore decode of the state register; BRANCH alone looks at zero_flag.
  always_comb begin
    alu_select = ALU_AND;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        alu_select = ALU_ADD;
        pc_source  = PCSRC_ALU;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_SEXT2;
        alu_select = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_SEXT;
        alu_select = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_select = r_alu;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        alu_select = r_alu;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_select = ALU_SUB;
        pc_source  = PCSRC_OUT;
        pc_write   = zero_flag;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_IMM_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = imm_src_b;
        alu_select = imm_alu;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: ;
    endcase

    // Reset must silence strobes immediately, not at the next edge.
    if (reset) begin
      alu_select = ALU_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_FOUR;
      pc_write   = 1'b0;
      pc_source  = PCSRC_ALU;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: directed plan plus random instruction stream against a per-class cycle model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] instr_opcode = 6'b0;
  logic [5:0] instr_funct = 6'b0;
  logic       zero_flag = 1'b0;
  logic [3:0] alu_select;
  logic       alu_src_a;
  logic [2:0] alu_src_b;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal;

  int total = 0;
  int bad = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr_opcode(instr_opcode), .instr_funct(instr_funct),
    .zero_flag(zero_flag), .alu_select(alu_select), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {alu4, a, b3, pcw, pcs2, iod, mr, mw, irw, rw, rd, m2r, ill}
  logic [18:0] obs;
  assign obs = {alu_select, alu_src_a, alu_src_b, pc_write, pc_source, i_or_d, mem_read,
                mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal};

  typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_J, C_IMM, C_ILL} cls_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] mk(input logic [3:0] alu, input logic a, input logic [2:0] b,
                                     input logic pcw, input logic [1:0] pcs, input logic iod,
                                     input logic mr, input logic mw, input logic irw, input logic rw,
                                     input logic rd, input logic m2r, input logic ill);
    return {alu, a, b, pcw, pcs, iod, mr, mw, irw, rw, rd, m2r, ill};
  endfunction

  function automatic logic [18:0] rst_vec();
    return mk(4'b0010, 0, 3'b001, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit imm_enabled();
`ifdef MIPS_CTRL_IMM_OPS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      default:   return 4'b0111;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return funct_ok(fn) ? C_R : C_ILL;
    if (op == 6'b100011) return C_LW;
    if (op == 6'b101011) return C_SW;
    if (op == 6'b000100) return C_BEQ;
    if (op == 6'b000010) return C_J;
    if (op inside {6'b001000, 6'b001010, 6'b001100, 6'b001101}) return imm_enabled() ? C_IMM : C_ILL;
    return C_ILL;
  endfunction

  function automatic int cycles(input cls_t c);
    case (c)
      C_LW:                return 5;
      C_SW, C_R, C_IMM:    return 4;
      default:             return 3;
    endcase
  endfunction

  // Expected outputs for cycle p (0 = fetch) of an instruction of class c.
  function automatic logic [18:0] expect_cyc(input cls_t c, input int p, input logic [5:0] op,
                                             input logic [5:0] fn, input logic zf);
    logic [3:0] ia;
    logic [2:0] ib;
    if (p == 0) return mk(4'b0010, 0, 3'b001, 1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0);
    if (p == 1) return mk(4'b0010, 0, 3'b011, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    case (c)
      C_LW, C_SW: begin
        if (p == 2) return mk(4'b0010, 1, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        if (c == C_SW) return mk(4'b0000, 0, 3'b000, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
        if (p == 3) return mk(4'b0000, 0, 3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
        return mk(4'b0000, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0);
      end
      C_R: begin
        if (p == 2) return mk(funct_alu(fn), 1, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        return mk(funct_alu(fn), 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
      end
      C_BEQ: return mk(4'b0110, 1, 3'b000, zf, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
      C_J:   return mk(4'b0000, 0, 3'b000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
      C_IMM: begin
        case (op)
          6'b001000: begin ia = 4'b0010; ib = 3'b010; end
          6'b001010: begin ia = 4'b0111; ib = 3'b010; end
          6'b001100: begin ia = 4'b0000; ib = 3'b100; end
          default:   begin ia = 4'b0001; ib = 3'b100; end
        endcase
        if (p == 2) return mk(ia, 1, ib, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        return mk(4'b0000, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
      end
      default: return mk(4'b0000, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    endcase
  endfunction

  // Called while the DUT sits in FETCH, just after a rising edge. zf < 0 randomises zero_flag per cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input int zf);
    cls_t c;
    int n;
    instr_opcode = op;
    instr_funct  = fn;
    c = classify(op, fn);
    n = cycles(c);
    for (int p = 0; p < n; p++) begin
      zero_flag = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      @(negedge clk);
      chk(tag, 32'(obs), 32'(expect_cyc(c, p, op, fn, zero_flag)));
      chk("excl", 32'({mem_read & mem_write, (int'(ir_write) + int'(reg_write) + int'(mem_write)) > 1}), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] rop, rfn;
  logic [5:0] legal_fn [5];

  initial begin
    legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
    legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;

    // Reset held three cycles with lw on the IR.
    instr_opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", 32'(obs), 32'(rst_vec()));
    end
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr("lw", 6'b100011, 6'b000000, 0);
    run_instr("r_sub", 6'b000000, 6'b100010, 0);
    run_instr("beq_z1", 6'b000100, 6'b000000, 1);
    run_instr("beq_z0", 6'b000100, 6'b000000, 0);
    run_instr("ill_op", 6'b111111, 6'b000000, 0);
    run_instr("ill_fn", 6'b000000, 6'b000111, 0);
    run_instr("ori", 6'b001101, 6'b000000, 0);
    run_instr("j", 6'b000010, 6'b000000, 0);
    run_instr("sw", 6'b101011, 6'b000000, 0);

    // Reset asserted asynchronously during MEM_WR of a store.
    instr_opcode = 6'b101011;
    instr_funct  = 6'b000000;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      chk("sw_pre_rst", 32'(obs), 32'(expect_cyc(C_SW, p, 6'b101011, 6'b0, zero_flag)));
      if (p < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #1 reset = 1'b1;
    #1 chk("rst_async_mw", 32'(mem_write), 32'd0);
    chk("rst_async_vec", 32'(obs), 32'(rst_vec()));
    @(posedge clk);
    @(negedge clk);
    chk("rst_held", 32'(obs), 32'(rst_vec()));
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr("after_rst", 6'b000000, 6'b100101, 0);

    // Random instruction stream.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2, 3: rop = 6'b000000;
        4: rop = 6'b000100;
        5: rop = 6'b000010;
        6: rop = 6'b001000;
        7: rop = 6'b001010;
        8: rop = ($urandom_range(0, 1) != 0) ? 6'b001100 : 6'b001101;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      rfn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      run_instr("rand", rop, rfn, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
